// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and requester ids.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic CPU_ID = 1'b0;
  localparam logic PER_ID = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = PER_ID;
    end else begin
      winner = CPU_ID;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and peripheral access to one data memory; each transaction is
// a fixed IDLE -> ACCESS -> RESP sequence of three cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic              id_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              last_reg;
  logic              winner;
  logic              any_req;
  logic              in_range;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last_reg),
    .winner (winner),
    .any    (any_req)
  );

  // Word index compared at 64 bits so no MEM_WORDS value can be truncated.
  assign in_range = 64'(addr_reg[ADDR_W-1:2]) < 64'(MEM_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      id_reg    <= CPU_ID;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      last_reg  <= PER_ID;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        id_reg    <= winner;
        we_reg    <= we[winner];
        addr_reg  <= winner ? addr1 : addr0;
        wdata_reg <= winner ? wdata1 : wdata0;
      end
      if (state_reg == RESP) begin
        last_reg <= id_reg;
      end
    end
  end

  // Outputs decode only registered state, so an async reset clears them at once.
  always_comb begin
    state_next = state_reg;
    ack        = 2'b00;
    err        = 1'b0;
    rdata      = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        mem_we     = we_reg & in_range;
        state_next = RESP;
      end
      RESP: begin
        ack        = (id_reg == PER_ID) ? 2'b10 : 2'b01;
        err        = ~in_range;
        if (in_range && !we_reg) rdata = mem_rdata;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions plus
// hand-written sequences for reset, round-robin and abort behaviour.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  ack;
  logic        err, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // Bench-side memory; preload port shares the single writing process.
  logic [31:0] ram [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[11:2]];
  end

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] e_mem_addr;
    logic        e_mem_we;
    logic [31:0] e_mem_wdata;
    logic [1:0]  e_ack;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // addr, data and expected results worked out by hand from the memory preload
    vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0,
                32'h10, 1'b0, 32'h0, 2'b01, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h12345678,
                32'h20, 1'b1, 32'h12345678, 2'b10, 1'b0, 32'h0};
    vecs[2] = '{2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0,
                32'h20, 1'b0, 32'h0, 2'b01, 1'b0, 32'h12345678};
    vecs[3] = '{2'b01, 2'b01, 32'h1000, 32'h0, 32'h77, 32'h0,
                32'h1000, 1'b0, 32'h77, 2'b01, 1'b1, 32'h0};
    vecs[4] = '{2'b10, 2'b00, 32'h0, 32'h1003, 32'h0, 32'h0,
                32'h1003, 1'b0, 32'h0, 2'b10, 1'b1, 32'h0};
    vecs[5] = '{2'b01, 2'b00, 32'hFFF, 32'h0, 32'h0, 32'h0,
                32'hFFF, 1'b0, 32'h0, 2'b01, 1'b0, 32'hCAFEF00D};
    // Tie after a CPU grant: peripheral wins, then CPU wins the next tie
    vecs[6] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0,
                32'h20, 1'b0, 32'h0, 2'b10, 1'b0, 32'h12345678};
    vecs[7] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0,
                32'h10, 1'b0, 32'h0, 2'b01, 1'b0, 32'hDEADBEEF};

    // Reset state while rst is low
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(2'b00));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_mem_we", 64'(mem_we), 64'(1'b0));
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_err", 64'(err), 64'(1'b0));

    preload(10'd4, 32'hDEADBEEF);
    preload(10'd0, 32'hAAAA5555);
    preload(10'd1023, 32'hCAFEF00D);
    preload(10'd12, 32'h0BADF00D);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", i), 64'(busy), 64'(1'b0));
      req = vecs[i].req; we = vecs[i].we;
      addr0 = vecs[i].addr0; addr1 = vecs[i].addr1;
      wdata0 = vecs[i].wdata0; wdata1 = vecs[i].wdata1;
      @(negedge clk);
      chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].e_mem_addr));
      chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].e_mem_we));
      chk($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_mem_wdata));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(1'b1));
      chk($sformatf("v%0d_ack_early", i), 64'(ack), 64'(2'b00));
      req = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vecs[i].e_ack));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].e_rdata));
      chk($sformatf("v%0d_resp_mem_we", i), 64'(mem_we), 64'(1'b0));
      chk($sformatf("v%0d_resp_mem_addr", i), 64'(mem_addr), 64'h0);
      $display("[TB] vector %0d req=%b we=%b ack=%b err=%b rdata=0x%08h", i,
               vecs[i].req, vecs[i].we, ack, err, rdata);
    end

    // Continuous dual requests from reset: acks 01,10,01,10 three cycles apart
    reset_pulse();
    req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k % 3 == 2)
        chk($sformatf("rr_ack_k%0d", k), 64'(ack), 64'(((k / 3) % 2 == 0) ? 2'b01 : 2'b10));
      else
        chk($sformatf("rr_ack_k%0d", k), 64'(ack), 64'(2'b00));
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rr_done_busy", 64'(busy), 64'(1'b0));
    $display("[TB] round-robin sequence done");

    // Reset during ACCESS of a write: mem_we drops at once, no ack, write lost
    @(negedge clk);
    req = 2'b01; we = 2'b01; addr0 = 32'h30; wdata0 = 32'h55;
    @(negedge clk);
    chk("abort_mem_we_before", 64'(mem_we), 64'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_we_async", 64'(mem_we), 64'(1'b0));
    chk("abort_busy_async", 64'(busy), 64'(1'b0));
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    chk("abort_no_ack", 64'(ack), 64'(2'b00));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_ack", 64'(ack), 64'(2'b00));
    req = 2'b01; addr0 = 32'h30;
    @(negedge clk);
    chk("post_abort_mem_addr", 64'(mem_addr), 64'h30);
    req = 2'b00;
    @(negedge clk);
    chk("post_abort_ack", 64'(ack), 64'(2'b01));
    chk("post_abort_rdata", 64'(rdata), 64'h0BADF00D);
    $display("[TB] abort sequence ack=%b rdata=0x%08h", ack, rdata);

    // CPU drops req in ACCESS: ack still pulses, nothing follows
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    chk("drop_ack", 64'(ack), 64'(2'b01));
    chk("drop_rdata", 64'(rdata), 64'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop_quiet_busy%0d", k), 64'(busy), 64'(1'b0));
      chk($sformatf("drop_quiet_ack%0d", k), 64'(ack), 64'(2'b00));
    end
    $display("[TB] drop sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
